// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory write and load paths.
package mips_mem_pkg;

   localparam int DEF_DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RF_WR  = 2'd1,
      MEM_WR = 2'd2,
      ERR    = 2'd3
   } state_t;

endpackage

// File: rtl/lane_steer.sv
// Little-endian byte-lane steering and alignment check for 32-bit stores.
// Purely combinational; no handshake.
module lane_steer
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic        misaligned
);

   always_comb begin
      wdata      = data;
      be         = 4'b0000;
      misaligned = 1'b0;
      case (size)
         SZ_BYTE: begin
            wdata = {4{data[7:0]}};
            be    = 4'b0001 << off;
         end
         SZ_HALF: begin
            wdata      = {2{data[15:0]}};
            be         = off[1] ? 4'b1100 : 4'b0011;
            misaligned = off[0];
         end
         SZ_WORD: begin
            wdata      = data;
            be         = 4'b1111;
            misaligned = (off != 2'b00);
         end
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/store_router.sv
// Steers one EX/MEM result to the register file or to data memory as a store.
// RF write and align error take 2 cycles; stores hold until ack or timeout; req_ready low while busy.
module store_router
   import mips_mem_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_sel,
   input  logic [31:0]       req_addr,
   input  logic [4:0]        req_reg,
   input  logic [DATA_W-1:0] req_data,
   input  logic [1:0]        req_size,
   output logic              mem_en,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              err_align,
   output logic              err_timeout,
   output logic              busy
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   state_t              state;
   logic [CW-1:0]       tmo_cnt;
   logic [DATA_W-1:0]   st_wdata;
   logic [3:0]          st_be;
   logic                st_misaligned;

   lane_steer u_lane_steer (
      .size       (req_size),
      .off        (req_addr[1:0]),
      .data       (req_data),
      .wdata      (st_wdata),
      .be         (st_be),
      .misaligned (st_misaligned)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         tmo_cnt     <= '0;
         req_ready   <= 1'b0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_be      <= '0;
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         rf_wdata    <= '0;
         err_align   <= 1'b0;
         err_timeout <= 1'b0;
         busy        <= 1'b0;
      end else begin
         rf_we       <= 1'b0;
         err_align   <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               busy      <= 1'b0;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (!req_sel) begin
                     state    <= RF_WR;
                     // $0 is hardwired: consume the request without a write strobe
                     rf_we    <= (req_reg != 5'd0);
                     rf_waddr <= req_reg;
                     rf_wdata <= req_data;
                  end else if (st_misaligned) begin
                     state     <= ERR;
                     err_align <= 1'b1;
                  end else begin
                     state     <= MEM_WR;
                     mem_en    <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= st_wdata;
                     mem_be    <= st_be;
                     tmo_cnt   <= CW'(1);
                  end
               end
            end
            RF_WR, ERR: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
            MEM_WR: begin
               // tmo_cnt equals the number of the edge being sampled; ack wins on the last one
               if (mem_ack || (tmo_cnt == CW'(ACK_TIMEOUT))) begin
                  state       <= IDLE;
                  mem_en      <= 1'b0;
                  mem_we      <= 1'b0;
                  req_ready   <= 1'b1;
                  busy        <= 1'b0;
                  err_timeout <= !mem_ack;
               end else begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_router.sv
// Randomized + directed scoreboard bench for store_router.
module tb_store_router;

   localparam int T = 15;
   localparam int EV_RF = 0, EV_MEM = 1, EV_ALIGN = 2, EV_TMO = 3;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      int          len;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_sel = 1'b0, mem_ack = 1'b0;
   logic [31:0] req_addr = '0, req_data = '0;
   logic [4:0]  req_reg = '0;
   logic [1:0]  req_size = '0;
   logic        req_ready, mem_en, mem_we, rf_we, err_align, err_timeout, busy;
   logic [31:0] mem_addr, mem_wdata, rf_wdata;
   logic [3:0]  mem_be;
   logic [4:0]  rf_waddr;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_fail = 0;

   store_router #(.DATA_W(32), .ACK_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_sel(req_sel), .req_addr(req_addr), .req_reg(req_reg), .req_data(req_data),
      .req_size(req_size), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err_align(err_align),
      .err_timeout(err_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a store of 2^size bytes must start on a multiple of its own size.
   function automatic void model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] w, output logic [3:0] be, output bit mis);
      int off;
      int nbytes;
      off    = int'(a[1:0]);
      nbytes = 1 << int'(sz);
      mis    = (sz == 2'd3) || ((off % nbytes) != 0);
      be     = 4'(((1 << nbytes) - 1) << off);
      case (sz)
         2'd0:    w = d[7:0] * 32'h0101_0101;
         2'd1:    w = d[15:0] * 32'h0001_0001;
         default: w = d;
      endcase
   endfunction

   task automatic pop_ev(input int kind, output ev_t e, output bit ok);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         ok = 0;
         $display("FAIL unexpected_event: got kind %0d, expected none at %0t", kind, $time);
      end else begin
         e  = exp_q.pop_front();
         ok = 1;
         chk("event_kind", 32'(kind), 32'(e.kind));
      end
   endtask

   // Monitor: pops one expectation per observed output event.
   initial begin
      ev_t         e;
      bit          ok;
      logic        prev_en;
      int          len;
      logic [31:0] cap_a, cap_d;
      logic [3:0]  cap_be;
      prev_en = 1'b0;
      len = 0;
      cap_a = '0; cap_d = '0; cap_be = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_en = 1'b0;
            len = 0;
            continue;
         end
         if (rf_we) begin
            pop_ev(EV_RF, e, ok);
            if (ok) begin
               chk("rf_waddr", 32'(rf_waddr), e.a);
               chk("rf_wdata", rf_wdata, e.d);
            end
         end
         if (mem_en) begin
            if (!prev_en) begin
               cap_a = mem_addr; cap_d = mem_wdata; cap_be = mem_be;
               chk("mem_we", 32'(mem_we), 32'd1);
            end else if (mem_addr !== cap_a || mem_wdata !== cap_d || mem_be !== cap_be) begin
               chk("mem_stable", mem_addr ^ cap_a ^ mem_wdata ^ cap_d, 32'd0);
            end
            len++;
         end else if (prev_en) begin
            pop_ev(EV_MEM, e, ok);
            if (ok) begin
               chk("mem_addr", cap_a, e.a);
               chk("mem_wdata", cap_d, e.d);
               chk("mem_be", 32'(cap_be), 32'(e.be));
               chk("mem_en_len", 32'(len), 32'(e.len));
            end
            len = 0;
         end
         prev_en = mem_en;
         if (err_align) pop_ev(EV_ALIGN, e, ok);
         if (err_timeout) pop_ev(EV_TMO, e, ok);
      end
   end

   // k = cycles until ack (1..T acks; > T never acks).
   task automatic send(input bit sel, input logic [31:0] addr, input logic [4:0] rg,
                       input logic [31:0] dat, input logic [1:0] sz, input int k);
      ev_t         e;
      logic [31:0] w;
      logic [3:0]  be;
      bit          mis;
      int          wt;
      @(negedge clk);
      req_valid = 1'b1; req_sel = sel; req_addr = addr; req_reg = rg;
      req_data = dat; req_size = sz;
      wt = 0;
      while (!req_ready && wt < 50) begin
         @(negedge clk);
         wt++;
      end
      if (!req_ready) begin
         chk("accept_wait", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      model(sz, addr, dat, w, be, mis);
      if (!sel) begin
         if (rg != 5'd0) exp_q.push_back('{EV_RF, 32'(rg), dat, 4'h0, 0});
      end else if (mis) begin
         exp_q.push_back('{EV_ALIGN, 32'h0, 32'h0, 4'h0, 0});
      end else begin
         exp_q.push_back('{EV_MEM, {addr[31:2], 2'b00}, w, be, (k <= T) ? k : T});
         if (k > T) exp_q.push_back('{EV_TMO, 32'h0, 32'h0, 4'h0, 0});
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr = $urandom; req_data = $urandom; req_sel = 1'($urandom);
      chk("ready_after_accept", 32'(req_ready), 32'd0);
      chk("busy_after_accept", 32'(busy), 32'd1);
      if (!sel || mis) begin
         mem_ack = 1'($urandom);
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end else if (k <= T) begin
         repeat (k - 1) @(posedge clk);
         #1 mem_ack = 1'b1;
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end else begin
         repeat (T) @(posedge clk);
         #1;
      end
      chk("ready_after_done", 32'(req_ready), 32'd1);
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("reset_outputs",
          {26'd0, req_ready, mem_en, rf_we, err_align, err_timeout, busy}, 32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_reset", 32'(req_ready), 32'd1);

      send(1'b0, 32'h0, 5'd5, 32'hDEAD_BEEF, 2'b10, 1);
      send(1'b1, 32'h1003, 5'd0, 32'h0000_00AB, 2'b00, 3);
      send(1'b1, 32'h2001, 5'd0, 32'h1234_5678, 2'b01, 1);
      send(1'b1, 32'h3000, 5'd0, 32'hCAFE_F00D, 2'b10, T + 5);
      send(1'b0, 32'h0, 5'd9, 32'h0000_0042, 2'b00, 1);
      send(1'b0, 32'h0, 5'd0, 32'h1111_1111, 2'b00, 1);
      send(1'b0, 32'h0, 5'd31, 32'h3131_3131, 2'b00, 1);
      send(1'b1, 32'h0000_0006, 5'd0, 32'h0000_BEEF, 2'b01, T);
      send(1'b1, 32'h0000_0008, 5'd0, 32'h0000_0001, 2'b11, 1);
      send(1'b1, 32'h0000_0102, 5'd0, 32'hFFFF_0000, 2'b10, 1);

      for (int i = 0; i < 80; i++) begin
         logic [4:0] rg;
         rg = 5'($urandom);
         if ($urandom_range(0, 7) == 0) rg = 5'd0;
         send(1'($urandom), $urandom, rg, $urandom, 2'($urandom), $urandom_range(1, T + 3));
      end

      // Reset in the middle of a store
      @(negedge clk);
      req_valid = 1'b1; req_sel = 1'b1; req_addr = 32'h80; req_size = 2'b10; req_data = $urandom;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst_release", 32'(req_ready), 32'd1);
      send(1'b1, 32'h40, 5'd0, 32'h0BAD_CAFE, 2'b10, 2);

      repeat (3) @(posedge clk);
      #1 chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
